// File: rtl/audio_i2s_shifter.sv
// audio_i2s_shifter
//
// Turns the MSX core's 16-bit stereo PCM samples into an I2S stream for the
// board codec. The block makes its own bit clock and LR clock. It latches one
// left/right pair at the start of every frame and shifts each word out MSB
// first, one bit-clock after the LR clock edge (standard I2S alignment).
//
// Optional feature: define AUDIO_SHIFTER_MIX_EN to build the centred-mix
// adder. When the macro is undefined, `mix` is ignored and samples always
// pass through unchanged.
//
// Parameters:
//   CLK_DIV    clk cycles per half bit-clock period (>= 1)
//   SLOT_BITS  bit-clocks per channel slot (>= 17)
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   ldata, rdata   left/right samples, two's complement
//   exchan         swap left and right
//   mix            enable centred mix (AUDIO_SHIFTER_MIX_EN builds only)
//   mute           latch zeros instead of the inputs
//   aud_bclk       I2S bit clock
//   aud_daclrck    LR clock, 0 = left slot, 1 = right slot
//   aud_dacdat     serial data, MSB first
//   sample_strobe  one-clk pulse when a sample pair is latched

module audio_i2s_shifter #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ldata,
  input  logic [15:0] rdata,
  input  logic        exchan,
  input  logic        mix,
  input  logic        mute,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat,
  output logic        sample_strobe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] WORD_END = BIT_W'(16);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             strobe_q, strobe_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      hold_r_q, hold_r_d;

  logic [15:0]      in_l, in_r;
  logic [15:0]      sw_l, sw_r;
  logic [15:0]      proc_l, proc_r;

  logic             shift_evt;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_pos;

  // Input conditioning: mute first, then the optional channel swap.
  always_comb begin
    in_l = mute ? 16'h0000 : ldata;
    in_r = mute ? 16'h0000 : rdata;
    sw_l = exchan ? in_r : in_l;
    sw_r = exchan ? in_l : in_r;
  end

`ifdef AUDIO_SHIFTER_MIX_EN
  logic signed [17:0] ext_l, ext_r, sum_l, sum_r;

  // Centred mix: each output is 3/4 of its own channel plus 1/4 of the other.
  // The 18-bit sum cannot overflow (worst case is exactly -2^17), and taking
  // bits [17:2] is the flooring arithmetic shift by two, which always fits
  // back into 16 bits.
  always_comb begin
    ext_l  = {{2{sw_l[15]}}, sw_l};
    ext_r  = {{2{sw_r[15]}}, sw_r};
    sum_l  = ext_l + ext_l + ext_l + ext_r;
    sum_r  = ext_r + ext_r + ext_r + ext_l;
    proc_l = mix ? sum_l[17:2] : sw_l;
    proc_r = mix ? sum_r[17:2] : sw_r;
  end
`else
  logic unused_mix;
  assign unused_mix = mix;

  // No mix hardware in this build: samples go through untouched.
  always_comb begin
    proc_l = sw_l;
    proc_r = sw_r;
  end
`endif

  // Next-state logic. The divider toggles the bit clock at terminal count.
  // Everything else only moves on a shift event (bit clock falling), so the
  // data and LR clock change together with the falling edge and hold still
  // for the whole high phase. The left word goes straight from the inputs
  // into the shift register at the frame start, so only the right word needs
  // a separate hold register until its slot begins.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    strobe_d  = 1'b0;
    shift_d   = shift_q;
    hold_r_d  = hold_r_q;
    shift_evt = 1'b0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      shift_evt = bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    bit_nxt  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    slot_pos = (bit_nxt >= SLOT) ? bit_nxt - SLOT : bit_nxt;

    if (shift_evt) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = (bit_nxt >= SLOT);
      if (bit_nxt == '0) begin
        hold_r_d = proc_r;
        shift_d  = proc_l;
        strobe_d = 1'b1;
        dat_d    = 1'b0;
      end else if (bit_nxt == SLOT) begin
        shift_d = hold_r_q;
        dat_d   = 1'b0;
      end else if (slot_pos <= WORD_END) begin
        dat_d   = shift_q[15];
        shift_d = {shift_q[14:0], 1'b0};
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  // State registers. Reset parks the bit counter on the last bit so that
  // the first shift event after release wraps to 0 and starts a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b1;
      dat_q     <= 1'b0;
      strobe_q  <= 1'b0;
      shift_q   <= '0;
      hold_r_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      dat_q     <= dat_d;
      strobe_q  <= strobe_d;
      shift_q   <= shift_d;
      hold_r_q  <= hold_r_d;
    end
  end

  assign aud_bclk      = bclk_q;
  assign aud_daclrck   = lrck_q;
  assign aud_dacdat    = dat_q;
  assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_i2s_shifter.sv
// Testbench for audio_i2s_shifter with default parameters.
// Decodes the serial stream back into words, checks frame formatting, reset
// behaviour, timing after reset release and strobe period, and compares the
// words against hand-written vectors and a behavioural model.

module tb_audio_i2s_shifter;

  localparam int FRAME_CYCLES = 512;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        ex;
    logic        mu;
    logic        mx;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] ldata  = 16'h0000;
  logic [15:0] rdata  = 16'h0000;
  logic        exchan = 1'b0;
  logic        mix    = 1'b0;
  logic        mute   = 1'b0;
  logic        aud_bclk, aud_daclrck, aud_dacdat, sample_strobe;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycle       = 0;
  int   lastStrobe  = 0;
  logic haveLast    = 1'b0;
  logic prevStrobe  = 1'b0;

  audio_i2s_shifter #(.CLK_DIV(4), .SLOT_BITS(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ldata         (ldata),
    .rdata         (rdata),
    .exchan        (exchan),
    .mix           (mix),
    .mute          (mute),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Strobe must be a single-cycle pulse, 512 cycles apart while reset is low.
  always @(negedge clk) begin
    if (reset) begin
      haveLast <= 1'b0;
    end else if (sample_strobe) begin
      if (haveLast) checkOutput("strobe_period", 32'(cycle - lastStrobe), FRAME_CYCLES);
      checkOutput("strobe_width", {31'd0, prevStrobe}, 32'd0);
      haveLast   <= 1'b1;
      lastStrobe <= cycle;
    end
    prevStrobe <= sample_strobe;
  end

  // Behavioural model: plain integer arithmetic with an explicit floor.
  function automatic int floorDiv4(input int x);
    int q;
    q = x / 4;
    if ((x % 4 != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void refModel(input vec_t v, output logic [15:0] el, output logic [15:0] er);
    int a, b, t;
    a = v.mu ? 0 : int'($signed(v.l));
    b = v.mu ? 0 : int'($signed(v.r));
    if (v.ex) begin
      t = a; a = b; b = t;
    end
`ifdef AUDIO_SHIFTER_MIX_EN
    if (v.mx) begin
      t = floorDiv4(3 * a + b);
      b = floorDiv4(3 * b + a);
      a = t;
    end
`endif
    el = a[15:0];
    er = b[15:0];
  endfunction

  task automatic applyStimulus(input vec_t v);
    ldata  = v.l;
    rdata  = v.r;
    exchan = v.ex;
    mute   = v.mu;
    mix    = v.mx;
  endtask

  function automatic vec_t randVec();
    vec_t v;
    logic [15:0] corner [4];
    corner[0] = 16'h8000; corner[1] = 16'h7FFF; corner[2] = 16'hFFFF; corner[3] = 16'h0000;
    v.l  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
    v.r  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
    v.ex = 1'($urandom_range(0, 1));
    v.mu = ($urandom_range(0, 7) == 0);
    v.mx = 1'($urandom_range(0, 1));
    v.el = '0;
    v.er = '0;
    return v;
  endfunction

  task automatic checkReset(input string tag);
    checkOutput(tag, {28'd0, aud_bclk, aud_daclrck, aud_dacdat, sample_strobe}, 32'b0100);
  endtask

  // Release reset between edges, then check bclk/lrck/strobe after each of
  // the first 8 clk edges.
  task automatic releaseAndCheck(input string tag);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_edge%0d", tag, n),
                  {29'd0, aud_bclk, aud_daclrck, sample_strobe},
                  {29'd0, (n >= 4 && n < 8) ? 1'b1 : 1'b0, (n < 8) ? 1'b1 : 1'b0, (n == 8) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic waitStrobe(input string tag);
    logic got = 1'b0;
    for (int w = 0; w < 2 * FRAME_CYCLES && !got; w++) begin
      @(negedge clk);
      got = sample_strobe;
    end
    if (!got) reportTimeout(tag);
  endtask

  // Wait for n rising edges of the bit clock; returns 0 on timeout.
  task automatic waitRises(input int n, output logic ok);
    logic prevB, rose;
    ok    = 1'b1;
    prevB = aud_bclk;
    for (int i = 0; i < n && ok; i++) begin
      rose = 1'b0;
      for (int w = 0; w < 40 && !rose; w++) begin
        @(negedge clk);
        rose  = aud_bclk & ~prevB;
        prevB = aud_bclk;
      end
      ok = rose;
    end
  endtask

  // Called right after a strobe edge. Samples the 64 bit slots on bit-clock
  // high phases, rebuilds both words, checks LRCK and zero padding, and
  // optionally applies the next stimulus at bit index chgIdx.
  task automatic checkFrame(input string tag, input logic [15:0] el, input logic [15:0] er,
                            input int chgIdx, input vec_t nxt);
    logic [15:0] lw, rw;
    logic        fmtOk, ok;
    lw    = '0;
    rw    = '0;
    fmtOk = 1'b1;
    for (int i = 0; i < 64; i++) begin
      waitRises(1, ok);
      if (!ok) begin
        reportTimeout({tag, "_bclk"});
        return;
      end
      if (aud_daclrck !== (i >= 32)) fmtOk = 1'b0;
      if (i >= 1 && i <= 16)       lw[16 - i] = aud_dacdat;
      else if (i >= 33 && i <= 48) rw[48 - i] = aud_dacdat;
      else if (aud_dacdat !== 1'b0) fmtOk = 1'b0;
      if (i == chgIdx) applyStimulus(nxt);
    end
    checkOutput({tag, "_left"},  {16'd0, lw}, {16'd0, el});
    checkOutput({tag, "_right"}, {16'd0, rw}, {16'd0, er});
    checkOutput({tag, "_format"}, {31'd0, fmtOk}, 32'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        none, cur, nxt;
    logic [15:0] el, er;
    logic        ok;

    none = '{default: '0};

    vecs.push_back('{l:16'hA5C3, r:16'h1234, ex:1'b0, mu:1'b0, mx:1'b0, el:16'hA5C3, er:16'h1234});
    vecs.push_back('{l:16'hA5C3, r:16'h1234, ex:1'b1, mu:1'b0, mx:1'b0, el:16'h1234, er:16'hA5C3});
    vecs.push_back('{l:16'hA5C3, r:16'h1234, ex:1'b0, mu:1'b1, mx:1'b0, el:16'h0000, er:16'h0000});
    vecs.push_back('{l:16'hA5C3, r:16'h1234, ex:1'b1, mu:1'b1, mx:1'b1, el:16'h0000, er:16'h0000});
    vecs.push_back('{l:16'hFFFF, r:16'h8000, ex:1'b0, mu:1'b0, mx:1'b0, el:16'hFFFF, er:16'h8000});
    vecs.push_back('{l:16'h0001, r:16'h7FFF, ex:1'b1, mu:1'b0, mx:1'b0, el:16'h7FFF, er:16'h0001});
`ifdef AUDIO_SHIFTER_MIX_EN
    vecs.push_back('{l:16'h4000, r:16'h0000, ex:1'b0, mu:1'b0, mx:1'b1, el:16'h3000, er:16'h1000});
    vecs.push_back('{l:16'h8000, r:16'h7FFF, ex:1'b0, mu:1'b0, mx:1'b1, el:16'hBFFF, er:16'h3FFF});
    vecs.push_back('{l:16'h4000, r:16'h0000, ex:1'b1, mu:1'b0, mx:1'b1, el:16'h1000, er:16'h3000});
    vecs.push_back('{l:16'hFFFF, r:16'h0000, ex:1'b0, mu:1'b0, mx:1'b1, el:16'hFFFF, er:16'hFFFF});
`else
    vecs.push_back('{l:16'h4000, r:16'h0000, ex:1'b0, mu:1'b0, mx:1'b1, el:16'h4000, er:16'h0000});
    vecs.push_back('{l:16'h8000, r:16'h7FFF, ex:1'b0, mu:1'b0, mx:1'b1, el:16'h8000, er:16'h7FFF});
`endif

    // Reset values and first frame.
    ldata = 16'hA5C3;
    rdata = 16'h1234;
    repeat (3) @(negedge clk);
    checkReset("reset_values");
    releaseAndCheck("first");
    checkFrame("first", 16'hA5C3, 16'h1234, -1, none);

    // A mid-frame change of ldata only shows up in the following frame.
    waitStrobe("hold_strobe0");
    nxt   = '{l:16'h5A3C, r:16'h1234, ex:1'b0, mu:1'b0, mx:1'b0, el:16'h0, er:16'h0};
    checkFrame("hold_old", 16'hA5C3, 16'h1234, 20, nxt);
    waitStrobe("hold_strobe1");
    checkFrame("hold_new", 16'h5A3C, 16'h1234, -1, none);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      waitStrobe($sformatf("vec%0d_strobe", i));
      checkFrame($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, -1, none);
    end

    // Reset in the middle of the right slot, then a fresh frame.
    applyStimulus('{l:16'h1111, r:16'h2222, ex:1'b0, mu:1'b0, mx:1'b0, el:16'h0, er:16'h0});
    waitStrobe("midreset_strobe");
    waitRises(41, ok);
    if (!ok) reportTimeout("midreset_bclk");
    reset = 1'b1;
    #1;
    checkReset("midreset_values");
    applyStimulus('{l:16'h0BEE, r:16'hC0DE, ex:1'b0, mu:1'b0, mx:1'b0, el:16'h0, er:16'h0});
    repeat (3) @(negedge clk);
    checkReset("midreset_hold");
    releaseAndCheck("rerun");
    checkFrame("rerun", 16'h0BEE, 16'hC0DE, -1, none);

    // Randomised frames; each frame's stimulus arrives mid-way through the
    // previous frame, so the latching window is exercised every time.
    cur = randVec();
    applyStimulus(cur);
    for (int k = 0; k < 30; k++) begin
      nxt = randVec();
      waitStrobe($sformatf("rand%0d_strobe", k));
      refModel(cur, el, er);
      checkFrame($sformatf("rand%0d", k), el, er, int'($urandom_range(1, 63)), nxt);
      cur = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
